matmul_stream_core: RTL and testbench

- Streaming KxK integer matrix-multiply engine behind a single AXI4-Stream slave input and a single AXI4-Stream master output.
- The first NUM_WEIGHT_TRANSFERS input words load a KxK weight matrix W.
- Every later input word carries one K-element data column d, and the block emits one output word holding the column r = W·d.
- The block sits between a DMA/stream source and a result sink. Results pass through an output FIFO of DEPTH entries.

---
 rtl/matmul_stream_core.sv | 162 ++++++++++++++++
 tb/tb_matmul_stream_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_core.sv
// matmul_stream_core: streaming KxK integer matrix-vector engine.
// The first NUM_WEIGHT_TRANSFERS input words load the weight matrix W.
// Each later input word carries a data column d, and the block emits W*d
// through an output FIFO.
// Optional macro SIGNED_ARITH_EN: when defined, weights, data and results
// are two's-complement; otherwise all arithmetic is unsigned.
module matmul_stream_core #(
  parameter int KERNEL_SIZE          = 3,
  parameter int DATA_WIDTH           = 8,
  parameter int WEIGHT_WIDTH         = 8,
  parameter int DEPTH                = 8,
  parameter int PTR_WIDTH            = 3,
  parameter int BUS_WIDTH            = 32,
  parameter int SUM_WIDTH            = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
  parameter int DATAOUT_WIDTH        = SUM_WIDTH * KERNEL_SIZE,
  parameter int NUM_WEIGHT_TRANSFERS =
    (WEIGHT_WIDTH * KERNEL_SIZE * KERNEL_SIZE + BUS_WIDTH - 1) / BUS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BUS_WIDTH-1:0]     s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     m_axis_tready,
  output logic [DATAOUT_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid
);

  localparam int K   = KERNEL_SIZE;
  localparam int NW  = K * K;
  localparam int EPW = BUS_WIDTH / WEIGHT_WIDTH;
  localparam int CW  = $clog2(NUM_WEIGHT_TRANSFERS + 1);
  localparam int OW  = PTR_WIDTH + 2;

  typedef enum logic {LOAD_W, COMPUTE} state_t;

  state_t                   state, next_state;
  logic [CW-1:0]            wcnt;
  logic [WEIGHT_WIDTH-1:0]  weight [NW];
  logic [SUM_WIDTH-1:0]     prod_d [NW];
  logic [SUM_WIDTH-1:0]     prod_q [NW];
  logic [SUM_WIDTH-1:0]     sum_d  [K];
  logic [SUM_WIDTH-1:0]     sum_q  [K];
  logic [DATAOUT_WIDTH-1:0] packed_sum;
  logic                     s1_valid, s2_valid;
  logic [DATAOUT_WIDTH-1:0] fifo_mem [DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]       count;
  logic [OW-1:0]            occupancy;
  logic                     in_accept, w_accept, d_accept;
  logic                     push, pop;

  // Widening to SUM_WIDTH before multiplying keeps the low product bits exact
  // in both unsigned and two's-complement modes.
  function automatic logic [SUM_WIDTH-1:0] extend_w(input logic [WEIGHT_WIDTH-1:0] v);
`ifdef SIGNED_ARITH_EN
    return {{(SUM_WIDTH-WEIGHT_WIDTH){v[WEIGHT_WIDTH-1]}}, v};
`else
    return {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, v};
`endif
  endfunction

  function automatic logic [SUM_WIDTH-1:0] extend_d(input logic [DATA_WIDTH-1:0] v);
`ifdef SIGNED_ARITH_EN
    return {{(SUM_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
`else
    return {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, v};
`endif
  endfunction

  // Credit counts results already queued plus those still in the pipeline.
  assign occupancy = OW'(count) + OW'(s1_valid) + OW'(s2_valid);
  assign in_accept = s_axis_tvalid && s_axis_tready;
  assign w_accept  = in_accept && (state == LOAD_W);
  assign d_accept  = in_accept && (state == COMPUTE);
  assign m_axis_tvalid = !rst && (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign push = s2_valid;

  // Next-state and input-ready decode.
  always_comb begin
    next_state    = state;
    s_axis_tready = 1'b0;
    case (state)
      LOAD_W: begin
        s_axis_tready = !rst;
        if (s_axis_tvalid && (wcnt == CW'(NUM_WEIGHT_TRANSFERS - 1)))
          next_state = COMPUTE;
      end
      COMPUTE: s_axis_tready = !rst && (occupancy < OW'(DEPTH));
      default: next_state = LOAD_W;
    endcase
  end

  // State register and weight loading; weights are frozen once computing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_W;
      wcnt  <= '0;
      for (int n = 0; n < NW; n++) weight[n] <= '0;
    end else begin
      state <= next_state;
      if (w_accept) begin
        for (int n = 0; n < NW; n++)
          if (n / EPW == int'(wcnt))
            weight[n] <= s_axis_tdata[BUS_WIDTH-1-(n%EPW)*WEIGHT_WIDTH -: WEIGHT_WIDTH];
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Products of every weight with its matching element of the incoming column.
  always_comb begin
    for (int n = 0; n < NW; n++)
      prod_d[n] = extend_w(weight[n]) *
                  extend_d(s_axis_tdata[BUS_WIDTH-1-(n%K)*DATA_WIDTH -: DATA_WIDTH]);
  end

  // Row sums of the registered products.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      sum_d[i] = '0;
      for (int k = 0; k < K; k++) sum_d[i] = sum_d[i] + prod_q[i*K+k];
    end
  end

  // Pack row sums with row 0 in the least significant lane.
  always_comb begin
    packed_sum = '0;
    for (int i = 0; i < K; i++) packed_sum[i*SUM_WIDTH +: SUM_WIDTH] = sum_q[i];
  end

  // Pipeline data registers; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (d_accept) for (int n = 0; n < NW; n++) prod_q[n] <= prod_d[n];
    if (s1_valid) for (int i = 0; i < K; i++) sum_q[i] <= sum_d[i];
    if (push) fifo_mem[wr_ptr] <= packed_sum;
  end

  // Pipeline valid tracking and FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= d_accept;
      s2_valid <= s1_valid;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream_core.sv
// tb_matmul_stream_core: directed self-checking bench for matmul_stream_core.
// Inputs change 2 time units after a rising edge; outputs are sampled on the
// falling edge, so a handshake seen there completes at the next rising edge.
module tb_matmul_stream_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        m_tready;
  logic [56:0] m_tdata;
  logic        m_tvalid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [56:0] data;
    int          cyc;
  } out_t;
  out_t outQ[$];

  matmul_stream_core dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid)
  );

  always #5 clk = ~clk;

  // Count rising edges so handshakes can be timestamped.
  always @(posedge clk) cyc <= cyc + 1;

  // Record each output transfer together with the edge that completes it.
  always @(negedge clk)
    if (!rst && m_tvalid && m_tready) outQ.push_back('{m_tdata, cyc + 1});

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [56:0] lanes(input int a, input int b, input int c);
    return {c[18:0], b[18:0], a[18:0]};
  endfunction

  // Move to the input drive point n cycles later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Offer one input word and hold it until accepted; returns the accepting edge.
  task automatic applyStimulus(input logic [31:0] word, output int acc_cyc);
    int t;
    t = 0;
    s_tdata  = word;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) checkOutput("accept_timeout", 64'(s_tready), 64'd1);
    @(posedge clk);
    #2;
    acc_cyc  = cyc;
    s_tvalid = 1'b0;
  endtask

  task automatic waitOutputs(input int n, input string tag);
    int t;
    t = 0;
    while (outQ.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    #2;
    if (outQ.size() < n) checkOutput(tag, 64'(outQ.size()), 64'(n));
  endtask

  task automatic popCheck(input string tag, input logic [56:0] expected);
    out_t o;
    if (outQ.size() == 0) begin
      checkOutput({tag, "_missing"}, 64'(outQ.size()), 64'd1);
    end else begin
      o = outQ.pop_front();
      checkOutput(tag, 64'(o.data), 64'(expected));
    end
  endtask

  initial begin
    int          acc;
    int          k;
    int          n0;
    logic [56:0] hold;
    logic [56:0] max_expected;

`ifdef SIGNED_ARITH_EN
    max_expected = lanes(3, 3, 3);
`else
    max_expected = lanes(195075, 195075, 195075);
`endif

    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;

    // Reset state.
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_s_tready", 64'(s_tready), 64'd0);
    checkOutput("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("reset_m_tdata", 64'(m_tdata), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("load_w_ready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #2;

    // Weight load W = 1..9 row-major, then the first column with latency check.
    applyStimulus(32'h01020304, n0);
    applyStimulus(32'h05060708, n0);
    applyStimulus(32'h09000000, n0);
    outQ.delete();
    applyStimulus(32'h0A0D1000, n0);
    waitOutputs(1, "first_col_timeout");
    if (outQ.size() > 0) checkOutput("latency_edge", 64'(outQ[0].cyc), 64'(n0 + 3));
    popCheck("first_col", lanes(84, 201, 318));
    @(negedge clk);
    checkOutput("tvalid_one_cycle", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #2;

    // Two more columns with one-cycle gaps.
    applyStimulus(32'h0B0E1100, n0);
    step(1);
    applyStimulus(32'h0C0F1200, n0);
    waitOutputs(2, "stream_timeout");
    popCheck("stream_col1", lanes(90, 216, 342));
    popCheck("stream_col2", lanes(96, 231, 366));

    // Backpressure: stall the sink and stream columns d=(k,0,0).
    m_tready = 1'b0;
    outQ.delete();
    acc = 0;
    k   = 1;
    for (int c = 0; c < 20; c++) begin
      s_tdata  = {k[7:0], 24'h0};
      s_tvalid = 1'b1;
      @(negedge clk);
      if (s_tready) begin
        acc++;
        k++;
      end
      @(posedge clk);
      #2;
    end
    s_tvalid = 1'b0;
    checkOutput("bp_accepted", 64'(acc), 64'd8);
    @(negedge clk);
    checkOutput("bp_ready_low", 64'(s_tready), 64'd0);
    checkOutput("bp_tvalid", 64'(m_tvalid), 64'd1);
    hold = m_tdata;
    checkOutput("bp_head", 64'(hold), 64'(lanes(1, 4, 7)));
    repeat (3) @(negedge clk);
    checkOutput("bp_stable", 64'(m_tdata), 64'(hold));
    @(posedge clk);
    #2;
    m_tready = 1'b1;
    waitOutputs(8, "bp_drain_timeout");
    for (int j = 1; j <= 8; j++) popCheck("bp_order", lanes(j, 4 * j, 7 * j));
    @(negedge clk);
    checkOutput("bp_ready_back", 64'(s_tready), 64'd1);
    @(posedge clk);
    #2;

    // Mid-operation reset with results pending in the FIFO.
    m_tready = 1'b0;
    applyStimulus(32'h01000000, n0);
    applyStimulus(32'h02000000, n0);
    step(4);
    @(negedge clk);
    checkOutput("pre_reset_tvalid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("in_reset_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("in_reset_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("post_reset_load_w", 64'(s_tready), 64'd1);
    @(posedge clk);
    #2;

    // A data-looking word after reset must load weights, not produce a result.
    outQ.delete();
    m_tready = 1'b1;
    applyStimulus(32'hFFFFFFFF, n0);
    step(4);
    checkOutput("weight_word_no_output", 64'(outQ.size()), 64'd0);

    // Maximum values: all weights and data 0xFF; unused low bytes are junk.
    applyStimulus(32'hFFFFFFFF, n0);
    applyStimulus(32'hFF123456, n0);
    applyStimulus(32'hFFFFFF5A, n0);
    waitOutputs(1, "max_timeout");
    popCheck("max_values", max_expected);
    step(6);
    checkOutput("no_stale_results", 64'(outQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
